// File: rtl/task_tick_engine.sv
// Per-tick task-timing engine: ages every valid slot, retires completed or
// deadline-missed tasks, queues one retirement event per slot and keeps
// saturating miss/pass/overflow/active statistics.
module task_tick_engine #(
    parameter int unsigned N   = 64,
    parameter int unsigned EW  = 16,
    parameter int unsigned DW  = 16,
    parameter int unsigned IDW = 8,
    parameter int unsigned CW  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                tick,
    input  logic [N-1:0]                        run,
    input  logic [(2+IDW+DW+EW)*N-1:0]          rt_in,
    output logic [(2+IDW+DW+EW)*N-1:0]          rt_out,
    output logic                                ev_valid,
    input  logic                                ev_ready,
    output logic                                ev_kind,
    output logic [IDW-1:0]                      ev_id,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] ev_slot,
    input  logic                                clear_stats,
    output logic [CW-1:0]                       miss_cnt,
    output logic [CW-1:0]                       pass_cnt,
    output logic [CW-1:0]                       ovf_cnt,
    output logic [$clog2(N+1)-1:0]              active_cnt
);

    localparam int unsigned W  = 2 + IDW + DW + EW;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = $clog2(N + 1);
    localparam int unsigned MW = (DW > EW) ? DW : EW;
    localparam int unsigned SUMW = CW + AW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    // State
    logic [W*N-1:0]          rt_q, rt_d;
    logic [N-1:0]            pend_q, pend_d;
    logic [N-1:0]            kind_q, kind_d;
    logic [N-1:0][IDW-1:0]   id_q, id_d;
    logic [CW-1:0]           miss_q, miss_d;
    logic [CW-1:0]           pass_q, pass_d;
    logic [CW-1:0]           ovf_q, ovf_d;
    logic [AW-1:0]           act_q, act_d;

    // Ageing results
    logic [W*N-1:0]          aged;
    logic [N-1:0]            miss_v;
    logic [N-1:0]            done_v;
    logic [N-1:0]            ret_v;
    logic [AW-1:0]           miss_n;
    logic [AW-1:0]           done_n;
    logic [AW-1:0]           act_n;
    logic [AW-1:0]           ovf_n;
    logic [N-1:0]            pop_mask;

    // Saturating accumulate of a per-tick increment into a counter
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [AW-1:0] b);
        logic [SUMW-1:0] s;
        s = SUMW'(a) + SUMW'(b);
        if (s > SUMW'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return s[CW-1:0];
    endfunction

    // Age each slot of rt_in and classify retirements; count results
    always_comb begin
        logic [EW-1:0]  e_o;
        logic [DW-1:0]  d_o;
        logic [EW-1:0]  e_n;
        logic [DW-1:0]  d_n;
        logic [IDW-1:0] id_o;
        logic           t_o;
        logic           v_o;
        aged   = rt_in;
        miss_v = '0;
        done_v = '0;
        ret_v  = '0;
        miss_n = '0;
        done_n = '0;
        act_n  = '0;
        e_o    = '0;
        d_o    = '0;
        e_n    = '0;
        d_n    = '0;
        id_o   = '0;
        t_o    = 1'b0;
        v_o    = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            e_o  = rt_in[W*i +: EW];
            d_o  = rt_in[W*i+EW +: DW];
            id_o = rt_in[W*i+EW+DW +: IDW];
            t_o  = rt_in[W*i+W-2];
            v_o  = rt_in[W*i+W-1];
            e_n  = (run[i] && (e_o != '0)) ? e_o - EW'(1) : e_o;
            d_n  = (d_o != '0) ? d_o - DW'(1) : '0;
            if (v_o) begin
                miss_v[i] = MW'(d_n) < MW'(e_n);
                done_v[i] = (e_n == '0);
                ret_v[i]  = miss_v[i] | done_v[i];
                aged[W*i +: W] = {~ret_v[i], (ret_v[i] ? 1'b0 : t_o), id_o, d_n, e_n};
            end
            miss_n = miss_n + AW'(miss_v[i]);
            done_n = done_n + AW'(done_v[i]);
            act_n  = act_n + AW'(aged[W*i+W-1]);
        end
    end

    // Present the lowest-index pending event and decode the pop
    always_comb begin
        ev_valid = |pend_q;
        ev_slot  = '0;
        ev_kind  = 1'b0;
        ev_id    = '0;
        pop_mask = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                ev_slot = SW'(i);
                ev_kind = kind_q[i];
                ev_id   = id_q[i];
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            pop_mask[i] = ev_valid && ev_ready && (ev_slot == SW'(i));
        end
    end

    // Next state: slot words, event queue and statistics
    always_comb begin
        rt_d   = rt_q;
        pend_d = pend_q & ~pop_mask;
        kind_d = kind_q;
        id_d   = id_q;
        miss_d = miss_q;
        pass_d = pass_q;
        ovf_d  = ovf_q;
        act_d  = act_q;
        ovf_n  = '0;
        if (tick) begin
            rt_d  = aged;
            act_d = act_n;
            for (int i = 0; i < int'(N); i++) begin
                if (ret_v[i]) begin
                    // An unpopped pending event on this slot is lost
                    if (pend_q[i] && !pop_mask[i]) begin
                        ovf_n = ovf_n + AW'(1);
                    end
                    pend_d[i] = 1'b1;
                    kind_d[i] = miss_v[i];
                    id_d[i]   = rt_in[W*i+EW+DW +: IDW];
                end
            end
        end
        if (clear_stats) begin
            miss_d = '0;
            pass_d = '0;
            ovf_d  = '0;
        end else if (tick) begin
            miss_d = sat_add(miss_q, miss_n);
            pass_d = sat_add(pass_q, done_n);
            ovf_d  = sat_add(ovf_q, ovf_n);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rt_q   <= '0;
            pend_q <= '0;
            kind_q <= '0;
            id_q   <= '0;
            miss_q <= '0;
            pass_q <= '0;
            ovf_q  <= '0;
            act_q  <= '0;
        end else begin
            rt_q   <= rt_d;
            pend_q <= pend_d;
            kind_q <= kind_d;
            id_q   <= id_d;
            miss_q <= miss_d;
            pass_q <= pass_d;
            ovf_q  <= ovf_d;
            act_q  <= act_d;
        end
    end

    assign rt_out     = rt_q;
    assign miss_cnt   = miss_q;
    assign pass_cnt   = pass_q;
    assign ovf_cnt    = ovf_q;
    assign active_cnt = act_q;

endmodule

// File: tb/tb_task_tick_engine.sv
// Directed self-checking bench for task_tick_engine (N=4, CW=4).
module tb_task_tick_engine;

    localparam int unsigned N   = 4;
    localparam int unsigned EW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned IDW = 8;
    localparam int unsigned CW  = 4;
    localparam int unsigned W   = 2 + IDW + DW + EW;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic [N-1:0]     run;
    logic [W*N-1:0]   rt_in;
    logic [W*N-1:0]   rt_out;
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_kind;
    logic [IDW-1:0]   ev_id;
    logic [1:0]       ev_slot;
    logic             clear_stats;
    logic [CW-1:0]    miss_cnt;
    logic [CW-1:0]    pass_cnt;
    logic [CW-1:0]    ovf_cnt;
    logic [2:0]       active_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task_tick_engine #(.N(N), .EW(EW), .DW(DW), .IDW(IDW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .rt_in(rt_in), .rt_out(rt_out),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_id(ev_id),
        .ev_slot(ev_slot), .clear_stats(clear_stats), .miss_cnt(miss_cnt),
        .pass_cnt(pass_cnt), .ovf_cnt(ovf_cnt), .active_cnt(active_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic v, input logic t, input logic [IDW-1:0] id,
                                        input logic [DW-1:0] d, input logic [EW-1:0] e);
        return {v, t, id, d, e};
    endfunction

    function automatic logic [W-1:0] slot_of(input int i);
        return rt_out[W*i +: W];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; run = '0; rt_in = '0; ev_ready = 1'b0; clear_stats = 1'b0;
        #12;
        check("rst_rt_out", 64'(rt_out != '0), 64'd0);
        check("rst_ev_valid", 64'(ev_valid), 64'd0);
        check("rst_counts", {48'd0, miss_cnt, pass_cnt, ovf_cnt, 1'b0, active_cnt}, 64'd0);
        rst = 1'b0;
        step();

        // Running completion on slot0
        rt_in = '0; rt_in[0 +: W] = mk(1, 1, 8'h05, 16'd10, 16'd1); run = 4'b0001; tick = 1'b1;
        step();
        tick = 1'b0;
        check("cmp_slot0", 64'(slot_of(0)), 64'(mk(0, 0, 8'h05, 16'd9, 16'd0)));
        check("cmp_ev", {ev_valid, ev_kind, ev_id, ev_slot}, {1'b1, 1'b0, 8'h05, 2'd0});
        check("cmp_pass", 64'(pass_cnt), 64'd1);
        check("cmp_active", 64'(active_cnt), 64'd0);
        ev_ready = 1'b1; step(); ev_ready = 1'b0;
        check("cmp_popped", 64'(ev_valid), 64'd0);

        // Deadline miss on slot2 (waiting)
        rt_in = '0; rt_in[2*W +: W] = mk(1, 0, 8'h22, 16'd3, 16'd3); run = 4'b0000; tick = 1'b1;
        step();
        tick = 1'b0;
        check("miss_slot2", 64'(slot_of(2)), 64'(mk(0, 0, 8'h22, 16'd2, 16'd3)));
        check("miss_ev", {ev_valid, ev_kind, ev_id, ev_slot}, {1'b1, 1'b1, 8'h22, 2'd2});
        check("miss_cnt", 64'(miss_cnt), 64'd1);
        ev_ready = 1'b1; step(); ev_ready = 1'b0;

        // Waiting ageing over three ticks, no retirement
        rt_in = '0; rt_in[W +: W] = mk(1, 0, 8'h33, 16'd8, 16'd4); run = 4'b0000; tick = 1'b1;
        step();
        rt_in = rt_out; step();
        rt_in = rt_out; step();
        tick = 1'b0;
        check("wait_slot1", 64'(slot_of(1)), 64'(mk(1, 0, 8'h33, 16'd5, 16'd4)));
        check("wait_noev", 64'(ev_valid), 64'd0);
        check("wait_active", 64'(active_cnt), 64'd1);

        // Two retirements, back-pressure, then ordered drain
        rt_in = '0;
        rt_in[0 +: W]   = mk(1, 0, 8'hA0, 16'd5, 16'd1);
        rt_in[3*W +: W] = mk(1, 0, 8'hA3, 16'd0, 16'd1);
        run = 4'b0001; tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {ev_valid, ev_kind, ev_id, ev_slot}, {1'b1, 1'b0, 8'hA0, 2'd0});
            step();
        end
        check("bp_counts", {miss_cnt, pass_cnt}, {4'd2, 4'd2});
        ev_ready = 1'b1; step();
        check("bp_second", {ev_valid, ev_kind, ev_id, ev_slot}, {1'b1, 1'b1, 8'hA3, 2'd3});
        step();
        check("bp_empty", 64'(ev_valid), 64'd0);
        ev_ready = 1'b0;

        // Clear statistics
        clear_stats = 1'b1; step(); clear_stats = 1'b0;
        check("clr_counts", {miss_cnt, pass_cnt, ovf_cnt}, 12'd0);

        // Overflow: overwrite an unpopped event
        rt_in = '0; rt_in[W +: W] = mk(1, 0, 8'h11, 16'd0, 16'd1); run = 4'b0000; tick = 1'b1;
        step();
        rt_in[W +: W] = mk(1, 0, 8'h44, 16'd1, 16'd2);
        step();
        tick = 1'b0;
        check("ovf_ev", {ev_valid, ev_kind, ev_id, ev_slot}, {1'b1, 1'b1, 8'h44, 2'd1});
        check("ovf_cnt", 64'(ovf_cnt), 64'd1);
        check("ovf_miss", 64'(miss_cnt), 64'd2);
        ev_ready = 1'b1; step(); ev_ready = 1'b0;
        check("ovf_drained", 64'(ev_valid), 64'd0);

        // Same case with a pop on the retiring cycle
        clear_stats = 1'b1; step(); clear_stats = 1'b0;
        rt_in = '0; rt_in[W +: W] = mk(1, 0, 8'h55, 16'd0, 16'd1); tick = 1'b1;
        step();
        rt_in[W +: W] = mk(1, 0, 8'h66, 16'd1, 16'd2); ev_ready = 1'b1;
        #1;
        check("pop_old_id", {ev_valid, ev_id}, {1'b1, 8'h55});
        step();
        tick = 1'b0; ev_ready = 1'b0;
        check("pop_new_ev", {ev_valid, ev_kind, ev_id, ev_slot}, {1'b1, 1'b1, 8'h66, 2'd1});
        check("pop_no_ovf", 64'(ovf_cnt), 64'd0);
        ev_ready = 1'b1; step();

        // Saturation: 20 completions with CW=4
        clear_stats = 1'b1; step(); clear_stats = 1'b0;
        rt_in = '0; rt_in[0 +: W] = mk(1, 0, 8'h01, 16'd10, 16'd1); run = 4'b0001; tick = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k == 14) check("sat_at15", 64'(pass_cnt), 64'd15);
        end
        tick = 1'b0;
        check("sat_pass", 64'(pass_cnt), 64'd15);
        check("sat_no_ovf", 64'(ovf_cnt), 64'd0);
        step();
        ev_ready = 1'b0;
        check("sat_drained", 64'(ev_valid), 64'd0);

        // One miss, then clear together with a tick producing two misses
        rt_in = '0; rt_in[2*W +: W] = mk(1, 0, 8'h22, 16'd3, 16'd3); run = 4'b0000; tick = 1'b1;
        step();
        check("pre_clr_miss", 64'(miss_cnt), 64'd1);
        rt_in = '0;
        rt_in[0 +: W] = mk(1, 0, 8'hB0, 16'd0, 16'd1);
        rt_in[W +: W] = mk(1, 0, 8'hB1, 16'd1, 16'd5);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        check("clr_tick_counts", {miss_cnt, pass_cnt, ovf_cnt}, 12'd0);
        check("clr_tick_active", 64'(active_cnt), 64'd0);

        // Build up state, then async reset between edges
        rt_in = '0;
        rt_in[0 +: W] = mk(1, 0, 8'hC0, 16'd5, 16'd1);
        rt_in[W +: W] = mk(1, 0, 8'h77, 16'd9, 16'd2);
        run = 4'b0001;
        step();
        tick = 1'b0;
        check("pre_rst_state", {pass_cnt, 1'b0, active_cnt}, {4'd1, 1'b0, 3'd1});
        #2;
        rst = 1'b1;
        #1;
        check("arst_rt_out", 64'(rt_out != '0), 64'd0);
        check("arst_ev_valid", 64'(ev_valid), 64'd0);
        check("arst_counts", {48'd0, miss_cnt, pass_cnt, ovf_cnt, 1'b0, active_cnt}, 64'd0);
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/task_tick_engine.md
# task_tick_engine

Clocked, parametrised per-tick task-timing engine for the scheduler's core array. On each scheduler tick it ages every valid task slot: it decrements the deadline, and also the execution time for slots marked running. It then retires completed or deadline-missed tasks, queues one retirement event per slot on a valid/ready port, and keeps saturating miss/pass/active statistics. It sits between the scheduler's slot array and the dispatcher/statistics logic, and covers both running-task and waiting-task ageing under one per-slot `run` mask.

## Interface
Parameters:
- N, 64: number of task slots (cores); N ≥ 1
- EW, 16: execution-time field width
- DW, 16: relative-deadline field width
- IDW, 8: task ID width
- CW, 32: statistics counter width
- Derived: W = 2+IDW+DW+EW. Slot word = {valid[W-1], type[W-2], id, deadline, exec}, exec in LSBs.

Ports:
- clk  in  1  clock; all sampling on rising edge
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle ageing strobe, synchronous to clk
- run  in  N  per-slot mode: 1 = running (exec and deadline age), 0 = waiting (deadline only)
- rt_in  in  W*N  packed slot words, slot i at [W*i+W-1 : W*i]
- rt_out  out  W*N  registered aged slot words, same packing
- ev_valid  out  1  retirement event available
- ev_ready  in  1  consumer accepts event
- ev_kind  out  1  1 = deadline miss, 0 = completed (pass)
- ev_id  out  IDW  ID of retired task
- ev_slot  out  clog2(N) (min 1)  slot index of retired task
- clear_stats  in  1  synchronous clear of all counters
- miss_cnt  out  CW  saturating count of misses
- pass_cnt  out  CW  saturating count of completions
- ovf_cnt  out  CW  saturating count of lost (overwritten) events
- active_cnt  out  clog2(N+1)  valid slots after last tick

## Operation
- Per-slot ageing at a tick, for a slot with valid=1:
  - e' = (run[i] && exec≠0) ? exec−1 : exec.
  - d' = (deadline≠0) ? deadline−1 : 0. Both are unsigned and never wrap.
  - miss = (d' < e'). done = (e' == 0). These are mutually exclusive by construction.
  - Retire on miss or done: output valid=0 and type=0. id, d' and e' are still written out.
  - Otherwise: valid=1, type and id unchanged, d' and e' written.
- Slots with valid=0 pass through unchanged.
- Event queue: per-slot pending bit plus a stored kind and id.
  - A tick retirement sets pending[i] and stores kind/id.
  - The presented event is the lowest-index pending slot. ev_* are driven combinationally from the pending registers; ev_valid = |pending.
  - An event pops (its pending bit clears) on a cycle where ev_valid && ev_ready.
  - Tick retirement on a slot that is already pending and not popped in the same cycle: the new kind/id overwrite the stored ones and ovf_cnt increments by 1.
  - Pop and tick retirement on the same slot in the same cycle: the popped event is the old one, the bit stays set with the new data, and ovf_cnt does not increment.
- Statistics, updated on tick cycles only:
  - miss_cnt and pass_cnt add the popcount of miss and done across the tick.
  - ovf_cnt adds the number of overwrites.
  - All three saturate at 2^CW−1.
  - active_cnt = number of slots with valid=1 in the new rt_out.
- clear_stats zeroes miss/pass/ovf_cnt. When asserted together with a tick, the clear wins: result is 0 and that tick's increments are dropped. active_cnt is not affected by clear_stats.
- Non-tick cycles: rt_out, counters and pending bits hold; only pops change state.

## Timing
- Reset (async assert, sync release): rt_out = 0, pending = 0, all counters = 0, ev_valid = 0.
- Latency: rt_out, pending and counters reflect a tick one edge after tick is sampled high. The first event is visible in the cycle after the tick edge.
- Event port: ev_kind/ev_id/ev_slot are stable while ev_valid=1 && ev_ready=0, unless a higher-priority (lower-index) slot becomes pending on a tick. Consumers must sample ev_* and ev_slot together.
- Throughput: one event popped per cycle. A tick is accepted every cycle, with no back-pressure on tick.
- Back-to-back ticks: each tick ages the rt_in presented that cycle. Upstream feeds rt_out back or loads new tasks.
- Reset mid-operation discards all pending events and statistics.

## Test plan
- Running completion: N=4; slot0 = {v=1,t=1,id=0x05,d=10,e=1}, run=1, tick → rt_out slot0 valid=0, e=0, d=9; ev {kind=0,id=0x05,slot=0}; pass_cnt=1, active_cnt=0.
- Miss: slot2 {v=1,id=0x22,d=3,e=3}, run=0, tick → d'=2 < e'=3, retired; ev {kind=1,id=0x22,slot=2}; miss_cnt=1.
- Waiting ageing without retire: slot1 {d=8,e=4}, run=0, three ticks → d=5, e=4, valid=1, no event, active_cnt=1.
- Event ordering and back-pressure: slots 0 and 3 retire on one tick, ev_ready=0 for 5 cycles → slot0 event held stable; then ev_ready=1 → slot0, then slot3, then ev_valid=0.
- Overflow: slot1 retires (id=0x11), not popped; slot1 reloaded with {d=1,e=2}, run=0, tick → miss, stored id overwritten, ovf_cnt=1. The same case with a pop in the same cycle gives ovf_cnt=0.
- Saturation and clear: CW=4 with 20 completions → pass_cnt=15. clear_stats together with a tick producing 2 misses → miss_cnt=0. Async rst mid-stream → all outputs 0 immediately.
